ara_perf_window_monitor: RTL and testbench



---
 rtl/ara_perf_window_monitor.sv | 111 +++++++++++
 tb/tb_ara_perf_window_monitor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ara_perf_window_monitor.sv
// Ara vector-window performance monitor: runtime and event counters, captured
// into snapshot registers each time a dispatched window drains back to idle.
module ara_perf_window_monitor #(
    parameter int unsigned NrEvents = 4,
    parameter int unsigned CntWidth = 64,
    parameter bit          Saturate = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         sw_en_i,
    input  logic                         vinsn_valid_i,
    input  logic                         ara_idle_i,
    input  logic [NrEvents-1:0]          events_i,
    input  logic                         clear_i,
    output logic [CntWidth-1:0]          runtime_o,
    output logic [NrEvents*CntWidth-1:0] event_snap_o,
    output logic                         snap_valid_o,
    output logic [15:0]                  snap_cnt_o,
    output logic [NrEvents:0]            ovf_o,
    output logic                         counting_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                            state, state_next;
    logic [CntWidth-1:0]               runtime_cnt, runtime_snap;
    logic [NrEvents-1:0][CntWidth-1:0] event_cnt, event_snap;
    logic                              pending, snap, snap_valid, counting;
    logic [15:0]                       snap_cnt;
    logic [NrEvents:0]                 ovf;

    function automatic logic [CntWidth-1:0] bump(input logic [CntWidth-1:0] value);
        if (Saturate && value == '1) return value;
        return value + CntWidth'(1);
    endfunction

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (vinsn_valid_i && sw_en_i) state_next = RUN;
            RUN:     if (!sw_en_i) state_next = ara_idle_i ? IDLE : DRAIN;
            DRAIN: begin
                if (sw_en_i)         state_next = RUN;
                else if (ara_idle_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign counting = (state != IDLE);
    // A window closes on the first idle cycle with no new request behind it.
    assign snap     = pending && ara_idle_i && !vinsn_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            pending      <= 1'b0;
            snap_valid   <= 1'b0;
            snap_cnt     <= '0;
            runtime_snap <= '0;
            event_snap   <= '0;
        end else if (clear_i) begin
            state        <= IDLE;
            pending      <= 1'b0;
            snap_valid   <= 1'b0;
            snap_cnt     <= '0;
            runtime_snap <= '0;
            event_snap   <= '0;
        end else begin
            state      <= state_next;
            snap_valid <= snap;
            if (snap) begin
                pending      <= 1'b0;
                snap_cnt     <= snap_cnt + 16'd1;
                runtime_snap <= runtime_cnt;
                event_snap   <= event_cnt;
            end else if (vinsn_valid_i) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            runtime_cnt <= '0;
            event_cnt   <= '0;
            ovf         <= '0;
        end else if (clear_i) begin
            runtime_cnt <= '0;
            event_cnt   <= '0;
            ovf         <= '0;
        end else if (counting) begin
            runtime_cnt <= bump(runtime_cnt);
            if (runtime_cnt == '1) ovf[0] <= 1'b1;
            for (int unsigned k = 0; k < NrEvents; k++) begin
                if (events_i[k]) begin
                    event_cnt[k] <= bump(event_cnt[k]);
                    if (event_cnt[k] == '1) ovf[k+1] <= 1'b1;
                end
            end
        end
    end

    assign runtime_o    = runtime_snap;
    assign event_snap_o = event_snap;
    assign snap_valid_o = snap_valid;
    assign snap_cnt_o   = snap_cnt;
    assign ovf_o        = ovf;
    assign counting_o   = counting;

endmodule

// File: tb/tb_ara_perf_window_monitor.sv
// Bench for ara_perf_window_monitor: 8-bit saturating and wrapping instances
// driven in lockstep, checked against an unbounded-count reference model.
module tb_ara_perf_window_monitor;

    localparam int NE = 4;
    localparam int CW = 8;

    typedef struct {
        logic [CW-1:0]    rt;
        logic [NE*CW-1:0] ev;
        logic [15:0]      cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic sw_en = 1'b0, vinsn = 1'b0, idle = 1'b1, clear = 1'b0;
    logic [NE-1:0] events = '0;

    logic [CW-1:0]    rt_s, rt_w;
    logic [NE*CW-1:0] ev_s, ev_w;
    logic             sv_s, sv_w, cnt_s, cnt_w;
    logic [15:0]      sc_s, sc_w;
    logic [NE:0]      ovf_s, ovf_w;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ara_perf_window_monitor #(.NrEvents(NE), .CntWidth(CW), .Saturate(1'b1)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .sw_en_i(sw_en), .vinsn_valid_i(vinsn),
        .ara_idle_i(idle), .events_i(events), .clear_i(clear),
        .runtime_o(rt_s), .event_snap_o(ev_s), .snap_valid_o(sv_s),
        .snap_cnt_o(sc_s), .ovf_o(ovf_s), .counting_o(cnt_s));

    ara_perf_window_monitor #(.NrEvents(NE), .CntWidth(CW), .Saturate(1'b0)) dut_wrap (
        .clk_i(clk), .rst_ni(rst_n), .sw_en_i(sw_en), .vinsn_valid_i(vinsn),
        .ara_idle_i(idle), .events_i(events), .clear_i(clear),
        .runtime_o(rt_w), .event_snap_o(ev_w), .snap_valid_o(sv_w),
        .snap_cnt_o(sc_w), .ovf_o(ovf_w), .counting_o(cnt_w));

    // Reference model: true (unbounded) counts; width effects applied on read-out.
    int unsigned m_rt, m_srt, m_snaps;
    int unsigned m_ev[NE];
    int unsigned m_sev[NE];
    logic        m_pend, m_active, m_sw_off;
    exp_t        q_s[$];
    exp_t        q_w[$];

    function automatic logic [CW-1:0] satv(input int unsigned v);
        return (v > 255) ? 8'hFF : v[7:0];
    endfunction

    function automatic logic [CW-1:0] wrapv(input int unsigned v);
        return 8'(v % 256);
    endfunction

    function automatic logic [NE*CW-1:0] pack_ev(input logic sat);
        logic [NE*CW-1:0] r;
        r = '0;
        for (int k = 0; k < NE; k++) r[k*CW +: CW] = sat ? satv(m_sev[k]) : wrapv(m_sev[k]);
        return r;
    endfunction

    function automatic logic [NE:0] exp_ovf();
        logic [NE:0] r;
        r[0] = (m_rt > 255);
        for (int k = 0; k < NE; k++) r[k+1] = (m_ev[k] > 255);
        return r;
    endfunction

    task automatic model_reset();
        m_rt = 0; m_srt = 0; m_snaps = 0;
        m_pend = 1'b0; m_active = 1'b0; m_sw_off = 1'b0;
        for (int k = 0; k < NE; k++) begin m_ev[k] = 0; m_sev[k] = 0; end
    endtask

    // Apply the rules for the edge about to happen with the inputs now driven.
    task automatic model_step();
        logic snap;
        exp_t e;
        if (clear) begin
            model_reset();
            return;
        end
        snap = m_pend && idle && !vinsn;
        if (snap) begin
            m_srt = m_rt;
            for (int k = 0; k < NE; k++) m_sev[k] = m_ev[k];
            m_snaps++;
        end
        if (m_active) begin
            m_rt++;
            for (int k = 0; k < NE; k++) if (events[k]) m_ev[k]++;
        end
        if (snap) m_pend = 1'b0;
        else if (vinsn) m_pend = 1'b1;
        if (!m_active) begin
            if (vinsn && sw_en) begin m_active = 1'b1; m_sw_off = 1'b0; end
        end else if (sw_en) begin
            m_sw_off = 1'b0;
        end else if (idle) begin
            m_active = 1'b0;
        end else begin
            m_sw_off = 1'b1;
        end
        if (snap) begin
            e.rt = satv(m_srt);  e.ev = pack_ev(1'b1); e.cnt = 16'(m_snaps); q_s.push_back(e);
            e.rt = wrapv(m_srt); e.ev = pack_ev(1'b0); e.cnt = 16'(m_snaps); q_w.push_back(e);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_live();
        chk("sat_counting", 64'(cnt_s), 64'(m_active));
        chk("wrap_counting", 64'(cnt_w), 64'(m_active));
        chk("sat_ovf", 64'(ovf_s), 64'(exp_ovf()));
        chk("wrap_ovf", 64'(ovf_w), 64'(exp_ovf()));
        chk("sat_runtime_held", 64'(rt_s), 64'(satv(m_srt)));
        chk("wrap_runtime_held", 64'(rt_w), 64'(wrapv(m_srt)));
        chk("sat_events_held", 64'(ev_s), 64'(pack_ev(1'b1)));
        chk("wrap_events_held", 64'(ev_w), 64'(pack_ev(1'b0)));
        chk("sat_snap_cnt", 64'(sc_s), 64'(16'(m_snaps)));
        chk("wrap_snap_cnt", 64'(sc_w), 64'(16'(m_snaps)));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_zero_sat"}, {rt_s, ev_s, sc_s, ovf_s, sv_s, cnt_s}, 64'd0);
        chk({tag, "_zero_wrap"}, {rt_w, ev_w, sc_w, ovf_w, sv_w, cnt_w}, 64'd0);
    endtask

    task automatic cyc(input logic s, input logic v, input logic i,
                       input logic [NE-1:0] e, input logic c);
        @(negedge clk);
        check_live();
        sw_en = s; vinsn = v; idle = i; events = e; clear = c;
        model_step();
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero(tag);
        model_reset();
        q_s.delete();
        q_w.delete();
        sw_en = 1'b0; vinsn = 1'b0; idle = 1'b1; events = '0; clear = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: every snapshot pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sv_s) begin
                total++;
                if (q_s.size() == 0) begin
                    bad++;
                    $display("FAIL sat_snap_pulse: got unexpected pulse, expected none at %0t", $time);
                end else begin
                    exp_t e;
                    e = q_s.pop_front();
                    total--;
                    chk("sat_snap_runtime", 64'(rt_s), 64'(e.rt));
                    chk("sat_snap_events", 64'(ev_s), 64'(e.ev));
                    chk("sat_snap_count", 64'(sc_s), 64'(e.cnt));
                end
            end
            if (sv_w) begin
                total++;
                if (q_w.size() == 0) begin
                    bad++;
                    $display("FAIL wrap_snap_pulse: got unexpected pulse, expected none at %0t", $time);
                end else begin
                    exp_t e;
                    e = q_w.pop_front();
                    total--;
                    chk("wrap_snap_runtime", 64'(rt_w), 64'(e.rt));
                    chk("wrap_snap_events", 64'(ev_w), 64'(e.ev));
                    chk("wrap_snap_count", 64'(sc_w), 64'(e.cnt));
                end
            end
        end
    end

    initial begin
        logic s, v, i, c;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single window with software disable while busy, events on the way.
        cyc(1, 1, 1, 4'b0001, 0);
        for (int k = 0; k < 10; k++)
            cyc((k < 4) ? 1'b1 : 1'b0, 0, 0, {1'b0, (k == 1 || k == 4 || k == 8), 1'b0, 1'b1}, 0);
        cyc(0, 0, 1, 4'b0001, 0);
        repeat (3) cyc(0, 0, 1, 4'b0000, 0);

        // Software disabled: no counting, snapshot still fires.
        cyc(0, 1, 1, 4'b1111, 0);
        cyc(0, 1, 0, 4'b1111, 0);
        cyc(0, 0, 1, 4'b1111, 0);
        repeat (2) cyc(0, 0, 1, 4'b0000, 0);

        // Two accumulating windows, idle coinciding with a new request.
        for (int w = 0; w < 2; w++) begin
            cyc(1, 1, 0, 4'b0010, 0);
            repeat (4 + 2 * w) cyc(1, 0, 0, 4'b0110, 0);
            cyc(1, 1, 1, 4'b0000, 0);
            cyc(0, 0, 1, 4'b1000, 0);
            cyc(0, 0, 1, 4'b0000, 0);
        end

        // Clear in RUN with pending set.
        cyc(1, 1, 0, 4'b1111, 0);
        repeat (3) cyc(1, 0, 0, 4'b1111, 0);
        cyc(1, 0, 1, 4'b1111, 1);
        cyc(0, 0, 1, 4'b0000, 0);
        cyc(0, 0, 1, 4'b0000, 0);

        // Long window past the 8-bit range: saturate vs wrap.
        cyc(1, 1, 0, 4'b0001, 0);
        repeat (300) cyc(1, 0, 0, {1'b0, 2'($urandom_range(0, 3)), 1'b1}, 0);
        cyc(0, 0, 1, 4'b0000, 0);
        repeat (2) cyc(0, 0, 1, 4'b0000, 0);

        // Reset in the middle of a window.
        cyc(1, 1, 0, 4'b0101, 0);
        repeat (5) cyc(1, 0, 0, 4'b0101, 0);
        do_reset("midrun");

        // Randomized traffic.
        s = 1'b0; i = 1'b1;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 9) == 0) s = ~s;
            if ($urandom_range(0, 3) == 0) i = ~i;
            v = ($urandom_range(0, 7) == 0);
            c = ($urandom_range(0, 199) == 0);
            cyc(s, v, i, 4'($urandom), c);
            if (n == 1200) do_reset("random");
        end
        repeat (4) cyc(0, 0, 1, 4'b0000, 0);
        @(negedge clk);
        chk("sat_queue_drained", 64'(q_s.size()), 64'd0);
        chk("wrap_queue_drained", 64'(q_w.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
